// File: rtl/master_frame_receiver.sv
// Serial ADC link receiver: recovers framed 16-bit words, splits them into lower/upper
// channels, checks parity and stop bit, and keeps a saturating link-error count.
module master_frame_receiver #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned ERR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 serial_data_in,
  output logic [15:0]          lower_adc_data,
  output logic                 lower_adc_valid,
  output logic [15:0]          upper_adc_data,
  output logic                 upper_adc_valid,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic [ERR_CNT_W-1:0] error_count,
  output logic                 busy
);

  localparam int unsigned TMR_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = 5;
  localparam int unsigned FRM_W = 18;
  localparam logic [TMR_W-1:0] HALF_BIT = TMR_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TMR_W-1:0] FULL_BIT = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRM_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BITS,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, rx_s_q;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [FRM_W-1:0]     shreg_q, shreg_d;
  logic [15:0]          lower_q, lower_d, upper_q, upper_d;
  logic                 lower_vld_q, lower_vld_d, upper_vld_q, upper_vld_d;
  logic                 par_err_q, par_err_d, frm_err_q, frm_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 busy_q;
  logic                 tmr_done_c;

  assign tmr_done_c = (tmr_q == '0);

  // Two-flop synchroniser, preset to the idle-high line level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= serial_data_in;
      rx_s_q  <= sync1_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      lower_q     <= '0;
      upper_q     <= '0;
      lower_vld_q <= 1'b0;
      upper_vld_q <= 1'b0;
      par_err_q   <= 1'b0;
      frm_err_q   <= 1'b0;
      err_cnt_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      lower_q     <= lower_d;
      upper_q     <= upper_d;
      lower_vld_q <= lower_vld_d;
      upper_vld_q <= upper_vld_d;
      par_err_q   <= par_err_d;
      frm_err_q   <= frm_err_d;
      err_cnt_q   <= err_cnt_d;
      busy_q      <= (state_d != S_IDLE);
    end
  end

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    lower_d     = lower_q;
    upper_d     = upper_q;
    lower_vld_d = 1'b0;
    upper_vld_d = 1'b0;
    par_err_d   = 1'b0;
    frm_err_d   = 1'b0;
    err_cnt_d   = err_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          tmr_d   = HALF_BIT;
        end
      end
      S_START: begin
        if (!tmr_done_c) begin
          tmr_d = tmr_q - TMR_W'(1);
        end else if (rx_s_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_BITS;
          tmr_d   = FULL_BIT;
          idx_d   = '0;
        end
      end
      S_BITS: begin
        if (!tmr_done_c) begin
          tmr_d = tmr_q - TMR_W'(1);
        end else begin
          shreg_d = {shreg_q[FRM_W-2:0], rx_s_q};
          tmr_d   = FULL_BIT;
          if (idx_q == LAST_IDX) state_d = S_STOP;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      S_STOP: begin
        // Framing error wins over parity so a frame yields at most one error pulse
        if (!tmr_done_c) begin
          tmr_d = tmr_q - TMR_W'(1);
        end else if (!rx_s_q) begin
          frm_err_d = 1'b1;
          state_d   = S_WAIT_IDLE;
        end else if (^shreg_q) begin
          par_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          state_d = S_IDLE;
          if (shreg_q[FRM_W-1]) begin
            upper_d     = shreg_q[16:1];
            upper_vld_d = 1'b1;
          end else begin
            lower_d     = shreg_q[16:1];
            lower_vld_d = 1'b1;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if ((par_err_d || frm_err_d) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign lower_adc_data  = lower_q;
  assign lower_adc_valid = lower_vld_q;
  assign upper_adc_data  = upper_q;
  assign upper_adc_valid = upper_vld_q;
  assign parity_error    = par_err_q;
  assign framing_error   = frm_err_q;
  assign error_count     = err_cnt_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_master_frame_receiver.sv
// Bench for master_frame_receiver: directed vector table, corner sequences and random
// frames checked against an event-level model of the link.
module tb_master_frame_receiver;
  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        serial_data_in;
  logic [15:0] lower_adc_data, upper_adc_data;
  logic        lower_adc_valid, upper_adc_valid;
  logic        parity_error, framing_error, busy;
  logic [7:0]  error_count;

  master_frame_receiver #(.CLKS_PER_BIT(CPB), .ERR_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .serial_data_in(serial_data_in),
    .lower_adc_data(lower_adc_data), .lower_adc_valid(lower_adc_valid),
    .upper_adc_data(upper_adc_data), .upper_adc_valid(upper_adc_valid),
    .parity_error(parity_error), .framing_error(framing_error),
    .error_count(error_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // kind: 0 lower valid, 1 upper valid, 2 parity error, 3 framing error
  typedef struct {
    int          kind;
    logic [15:0] data;
    logic [15:0] lower;
    logic [15:0] upper;
    logic [7:0]  err;
  } exp_t;

  typedef struct {
    logic        chan;
    logic [15:0] data;
    logic        flip_par;
    logic        bad_stop;
    int          hold_low;
    int          gap;
    int          kind;
    logic [15:0] lower;
    logic [15:0] upper;
    logic [7:0]  err;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        vecs[6];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] m_lower = '0, m_upper = '0;
  logic [7:0]  m_err = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected outcome of one frame, derived from its fields
  task automatic model_push(input logic chan, input logic [15:0] d, input logic par_bit,
                            input logic stop_bit);
    exp_t e;
    if (!stop_bit) begin
      e.kind = 3;
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
    end else if (^{chan, d, par_bit}) begin
      e.kind = 2;
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
    end else begin
      e.kind = chan ? 1 : 0;
      if (chan) m_upper = d;
      else      m_lower = d;
    end
    e.data  = d;
    e.lower = m_lower;
    e.upper = m_upper;
    e.err   = m_err;
    exp_q.push_back(e);
  endtask

  task automatic got_event(input int k, input logic [15:0] d);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event kind=%0d data=%h required=none", k, d);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", 32'(k), 32'(e.kind));
      if (e.kind < 2) chk("event_data", 32'(d), 32'(e.data));
      chk("lower_adc_data", 32'(lower_adc_data), 32'(e.lower));
      chk("upper_adc_data", 32'(upper_adc_data), 32'(e.upper));
      chk("error_count", 32'(error_count), 32'(e.err));
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (lower_adc_valid) got_event(0, lower_adc_data);
      if (upper_adc_valid) got_event(1, upper_adc_data);
      if (parity_error)    got_event(2, 16'h0000);
      if (framing_error)   got_event(3, 16'h0000);
    end
  end

  task automatic send_frame(input logic chan, input logic [15:0] d, input logic par_bit,
                            input logic stop_bit, input int hold_low, input int gap);
    logic [19:0] fb;
    fb = {1'b0, chan, d, par_bit, stop_bit};
    for (int i = 19; i >= 0; i--) begin
      serial_data_in = fb[i];
      repeat (CPB) @(negedge clk);
    end
    if (!stop_bit) begin
      repeat (hold_low * CPB) @(negedge clk);
      chk("wait_idle_busy", 32'(busy), 32'd1);
      serial_data_in = 1'b1;
      repeat (CPB) @(negedge clk);
    end
    serial_data_in = 1'b1;
    repeat (gap * CPB) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("pending_events", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Line went low at the current negedge; release it after one clock and time busy
  task automatic probe_false_start(input string tag);
    int n;
    bit seen = 1'b0;
    bit done = 1'b0;
    @(negedge clk);
    serial_data_in = 1'b1;
    n = 1;
    if (busy) seen = 1'b1;
    while (!done && n < 12) begin
      @(negedge clk);
      n++;
      if (busy) seen = 1'b1;
      else if (seen) done = 1'b1;
    end
    chk({tag, "_busy_seen"}, 32'(seen), 32'd1);
    chk({tag, "_busy_low_in_time"}, 32'(n <= CPB / 2 + 3), 32'd1);
    repeat (10) @(negedge clk);
    chk({tag, "_no_event"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_lower_data"}, 32'(lower_adc_data), 32'd0);
    chk({tag, "_upper_data"}, 32'(upper_adc_data), 32'd0);
    chk({tag, "_valids"}, 32'({lower_adc_valid, upper_adc_valid}), 32'd0);
    chk({tag, "_errors"}, 32'({parity_error, framing_error}), 32'd0);
    chk({tag, "_error_count"}, 32'(error_count), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic        c, p, s;
    logic [15:0] d;
    int          r;
    exp_t        e;

    vecs[0] = '{1'b0, 16'hA5C3, 1'b0, 1'b0, 0, 3, 0, 16'hA5C3, 16'h0000, 8'd0};
    vecs[1] = '{1'b1, 16'h0001, 1'b0, 1'b0, 0, 0, 1, 16'hA5C3, 16'h0001, 8'd0};
    vecs[2] = '{1'b0, 16'hFFFF, 1'b0, 1'b0, 0, 3, 0, 16'hFFFF, 16'h0001, 8'd0};
    vecs[3] = '{1'b1, 16'h5A5A, 1'b1, 1'b0, 0, 3, 2, 16'hFFFF, 16'h0001, 8'd1};
    vecs[4] = '{1'b0, 16'h0F0F, 1'b0, 1'b1, 10, 2, 3, 16'hFFFF, 16'h0001, 8'd2};
    vecs[5] = '{1'b0, 16'h1234, 1'b0, 1'b0, 0, 3, 0, 16'h1234, 16'h0001, 8'd2};

    reset = 1'b1;
    serial_data_in = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // Directed vectors: good, back-to-back, bad parity, framing with stuck-low line
    foreach (vecs[i]) begin
      e.kind  = vecs[i].kind;
      e.data  = vecs[i].data;
      e.lower = vecs[i].lower;
      e.upper = vecs[i].upper;
      e.err   = vecs[i].err;
      exp_q.push_back(e);
      p = (^{vecs[i].chan, vecs[i].data}) ^ vecs[i].flip_par;
      send_frame(vecs[i].chan, vecs[i].data, p, !vecs[i].bad_stop,
                 vecs[i].hold_low, vecs[i].gap);
    end
    wait_drain(200);
    chk("busy_after_table", 32'(busy), 32'd0);
    m_lower = vecs[5].lower;
    m_upper = vecs[5].upper;
    m_err   = vecs[5].err;

    // Single-clock glitch on the idle line
    serial_data_in = 1'b0;
    probe_false_start("glitch");

    // Random frames with random gaps and occasional corruption
    for (int i = 0; i < 40; i++) begin
      c = 1'($urandom_range(0, 1));
      d = 16'($urandom());
      r = $urandom_range(0, 9);
      p = (^{c, d}) ^ (r < 2);
      s = (r != 2);
      model_push(c, d, p, s);
      send_frame(c, d, p, s, $urandom_range(0, 3), $urandom_range(0, 2));
    end
    wait_drain(200);

    // Reset in the middle of the data bits
    serial_data_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      serial_data_in = 1'(i % 2);
      repeat (CPB) @(negedge clk);
    end
    reset = 1'b1;
    serial_data_in = 1'b1;
    @(negedge clk);
    chk_all_zero("mid_frame_reset");
    reset = 1'b0;
    m_lower = '0;
    m_upper = '0;
    m_err   = '0;
    repeat (3 * 20 * CPB) @(negedge clk);
    chk_all_zero("after_reset");

    // Line held low through reset release is seen as a new start
    reset = 1'b1;
    serial_data_in = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    probe_false_start("low_after_reset");

    // Error counter saturation with back-to-back bad-parity frames
    for (int i = 0; i < 300; i++) begin
      c = 1'($urandom_range(0, 1));
      d = 16'($urandom());
      p = ~(^{c, d});
      model_push(c, d, p, 1'b1);
      send_frame(c, d, p, 1'b1, 0, 0);
    end
    wait_drain(200);
    chk("error_count_saturated", 32'(error_count), 32'd255);
    chk("data_held_zero", 32'({lower_adc_data, upper_adc_data}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
